uart_tx_arbiter: RTL and testbench

Shares the mother board's single `uart_tx` line between two byte-wide requesters, for example the CPU store path and a debug/echo source. It grants requesters round-robin and latches the winning byte. It then serialises the byte as an 8N1 UART frame, with every bit held `WAIT` clocks, matching the bit timing used by the board's `uart_rx` side. It sits between the memory-mapped I/O logic and the top-level `uart_tx` pin.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_serializer.sv | 102 ++++++++++
 rtl/uart_tx_arbiter.sv | 58 +++++
 tb/tb_uart_tx_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and default bit period.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_WAIT      = 868;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Two-requester byte handshake bundle feeding the shared UART transmitter.
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic                      req0_valid;
  logic [UART_DATA_BITS-1:0] req0_data;
  logic                      req0_ready;
  logic                      req1_valid;
  logic [UART_DATA_BITS-1:0] req1_data;
  logic                      req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: loads a byte in IDLE and shifts it out LSB first, each bit held WAIT clocks.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int WAIT = UART_WAIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_load,
  input  logic [UART_DATA_BITS-1:0] i_data,
  output logic                      o_ready,
  output logic                      o_busy,
  output logic                      o_tx
);

  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_state_nxt;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_nxt;
  logic [BW-1:0]             r_bit;
  logic [BW-1:0]             w_bit_nxt;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic [UART_DATA_BITS-1:0] w_shreg_nxt;
  logic                      r_tx;
  logic                      w_tx_nxt;
  logic                      w_expire;

  assign w_expire = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (i_load) begin
          w_state_nxt = START;
          w_shreg_nxt = i_data;
        end
      end
      START: begin
        if (w_expire) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_expire) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = r_shreg >> 1;
          if (r_bit == LAST_BIT) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit + 1'b1;
        end
      end
      STOP: begin
        if (w_expire) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The line level is registered from the next state so it changes on the same edge as the FSM.
  always_comb begin
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign o_ready = (r_state == IDLE) && reset;
  assign o_busy  = (r_state != IDLE);
  assign o_tx    = r_tx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line between two byte requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int WAIT = UART_WAIT
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    req,
  output logic                uart_tx,
  output logic                busy,
  output logic                grant_id
);

  logic                      r_last;
  logic                      r_grant;
  logic                      w_winner;
  logic                      w_idle;
  logic                      w_load;
  logic [UART_DATA_BITS-1:0] w_data;

  // A tie goes to whoever did not win last time.
  always_comb begin
    w_winner = ~r_last;
    if (req.req0_valid && !req.req1_valid)      w_winner = 1'b0;
    else if (!req.req0_valid && req.req1_valid) w_winner = 1'b1;
  end

  assign req.req0_ready = w_idle && req.req0_valid && !w_winner;
  assign req.req1_ready = w_idle && req.req1_valid &&  w_winner;
  assign w_load         = req.req0_ready || req.req1_ready;
  assign w_data         = w_winner ? req.req1_data : req.req0_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last  <= 1'b1;
      r_grant <= 1'b0;
    end else if (w_load) begin
      r_last  <= w_winner;
      r_grant <= w_winner;
    end
  end

  uart_tx_serializer #(
    .WAIT (WAIT)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_data),
    .o_ready (w_idle),
    .o_busy  (busy),
    .o_tx    (uart_tx)
  );

  assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected {grant,byte}; a line monitor decodes frames and compares.
module tb_uart_tx_arbiter;

  localparam int WAIT = 4;
  localparam int FLEN = 10 * WAIT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_tx, busy, grant_id;

  uart_tx_arbiter_if req_if ();

  uart_tx_arbiter #(.WAIT(WAIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req_if),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int acc0 = 0;
  int acc1 = 0;
  int both_rdy = 0;
  int frames_done = 0;
  int starts[$];
  logic [8:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_if.req0_valid && req_if.req0_ready) acc0 <= acc0 + 1;
    if (req_if.req1_valid && req_if.req1_ready) acc1 <= acc1 + 1;
    if (req_if.req0_ready && req_if.req1_ready) both_rdy <= both_rdy + 1;
  end

  // Loopback receiver: captures every cycle of a frame, then checks shape and data.
  initial begin : monitor
    logic       prev_tx;
    logic       line [FLEN];
    int         n;
    logic       ok;
    logic       gid;
    logic [7:0] dbyte;
    logic [8:0] e;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (reset && prev_tx && !uart_tx) begin
        starts.push_back(cyc);
        gid = grant_id;
        n = 0;
        for (int i = 0; i < FLEN; i++) begin
          if (i > 0) @(negedge clk);
          if (!reset) break;
          line[i] = uart_tx;
          n++;
        end
        if (n == FLEN) begin
          ok = !line[0] && line[9*WAIT];
          for (int b = 0; b < 10; b++)
            for (int c = 1; c < WAIT; c++)
              if (line[b*WAIT+c] !== line[b*WAIT]) ok = 1'b0;
          for (int b = 0; b < 8; b++) dbyte[b] = line[(b+1)*WAIT];
          chk("frame_shape", ok, 1);
          chk("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_data", dbyte, e[7:0]);
            chk("frame_grant", gid, e[8]);
          end
          frames_done++;
        end
      end
      prev_tx = uart_tx;
    end
  end

  task automatic wait_acc(input int n0, input int n1, input string nm);
    int b = 0;
    while ((acc0 < n0 || acc1 < n1) && b < 500) begin
      @(posedge clk); #1;
      b++;
    end
    chk(nm, (acc0 >= n0) && (acc1 >= n1), 1);
  endtask

  task automatic wait_frames(input int n, input string nm);
    int b = 0;
    while (frames_done < n && b < 1000) begin
      @(negedge clk);
      b++;
    end
    chk(nm, frames_done >= n, 1);
  endtask

  task automatic chk_gaps(input int s0, input int cnt, input string nm);
    for (int k = 0; k < cnt; k++)
      chk(nm, (starts.size() > s0 + k + 1) ? starts[s0+k+1] - starts[s0+k] : 0, FLEN + 1);
  endtask

  initial begin : stim
    int a0, a1, fd, s0;
    req_if.req0_valid = 1'b0; req_if.req0_data = '0;
    req_if.req1_valid = 1'b0; req_if.req1_data = '0;

    // Reset held for 5 cycles
    repeat (5) begin
      @(negedge clk);
      chk("rst_tx", uart_tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", {req_if.req0_ready, req_if.req1_ready}, 0);
    end
    chk("rst_grant", grant_id, 0);
    @(posedge clk); #1; reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single byte from requester 0
    a0 = acc0; fd = frames_done;
    exp_q.push_back({1'b0, 8'h55});
    req_if.req0_data = 8'h55; req_if.req0_valid = 1'b1;
    #1 chk("single_ready", req_if.req0_ready, 1);
    wait_acc(a0 + 1, acc1, "single_accept");
    chk("single_busy", busy, 1);
    chk("single_tx_low", uart_tx, 0);
    chk("single_ready_drop", req_if.req0_ready, 0);
    chk("single_grant", grant_id, 0);
    req_if.req0_valid = 1'b0;
    wait_frames(fd + 1, "single_frame");
    chk("single_pulses", acc0 - a0, 1);
    @(negedge clk);
    chk("single_idle_busy", busy, 0);

    // Lone requester 1: 0xFF then 0x00 back-to-back
    a1 = acc1; fd = frames_done; s0 = starts.size();
    exp_q.push_back({1'b1, 8'hFF});
    exp_q.push_back({1'b1, 8'h00});
    @(posedge clk); #1;
    req_if.req1_data = 8'hFF; req_if.req1_valid = 1'b1;
    wait_acc(acc0, a1 + 1, "lone_accept0");
    req_if.req1_data = 8'h00;
    wait_acc(acc0, a1 + 2, "lone_accept1");
    req_if.req1_valid = 1'b0;
    wait_frames(fd + 2, "lone_frames");
    chk_gaps(s0, 1, "lone_gap");

    // Tie: both valid, expect A1,B2,A1,B2
    a0 = acc0; a1 = acc1; fd = frames_done; s0 = starts.size();
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b1, 8'hB2});
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b1, 8'hB2});
    @(posedge clk); #1;
    req_if.req0_data = 8'hA1; req_if.req1_data = 8'hB2;
    req_if.req0_valid = 1'b1; req_if.req1_valid = 1'b1;
    wait_acc(a0 + 2, a1 + 2, "tie_accept");
    req_if.req0_valid = 1'b0; req_if.req1_valid = 1'b0;
    wait_frames(fd + 4, "tie_frames");
    chk_gaps(s0, 3, "tie_gap");

    // Reset during data bit 3 of 0x3C
    a0 = acc0;
    @(posedge clk); #1;
    req_if.req0_data = 8'h3C; req_if.req0_valid = 1'b1;
    wait_acc(a0 + 1, acc1, "mr_accept");
    req_if.req0_valid = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    chk("mr_busy_before", busy, 1);
    chk("mr_bit3", uart_tx, 1);
    reset = 1'b0;
    #1;
    chk("mr_tx_async", uart_tx, 1);
    chk("mr_busy_async", busy, 0);
    req_if.req0_data = 8'h3C; req_if.req1_data = 8'h99;
    req_if.req0_valid = 1'b1; req_if.req1_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mr_ready_in_reset", {req_if.req0_ready, req_if.req1_ready}, 0);
    end
    a0 = acc0; a1 = acc1; fd = frames_done;
    exp_q.push_back({1'b0, 8'h3C});
    @(posedge clk); #1; reset = 1'b1;
    wait_acc(a0 + 1, a1, "mr_reaccept");
    req_if.req0_valid = 1'b0; req_if.req1_valid = 1'b0;
    chk("mr_req1_not_taken", acc1 - a1, 0);
    wait_frames(fd + 1, "mr_frame");

    // Requester 1 withdraws its valid while the line is busy
    a0 = acc0; a1 = acc1; fd = frames_done;
    exp_q.push_back({1'b0, 8'h5A});
    @(posedge clk); #1;
    req_if.req0_data = 8'h5A; req_if.req0_valid = 1'b1;
    wait_acc(a0 + 1, a1, "wd_accept");
    req_if.req0_valid = 1'b0;
    req_if.req1_data = 8'hC3; req_if.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_if.req1_valid = 1'b0;
    wait_frames(fd + 1, "wd_frame0");
    exp_q.push_back({1'b0, 8'h66});
    @(posedge clk); #1;
    req_if.req0_data = 8'h66; req_if.req0_valid = 1'b1;
    wait_acc(a0 + 2, a1, "wd_accept2");
    req_if.req0_valid = 1'b0;
    wait_frames(fd + 2, "wd_frame1");
    chk("wd_req1_never_ready", acc1 - a1, 0);
    repeat (FLEN + 5) @(negedge clk);
    chk("wd_no_extra_frame", frames_done, fd + 2);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("one_ready_only", both_rdy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
